// File: rtl/bmu_cnt_pipe_if.sv
// Upstream/downstream handshake bundle for the bit-count pipeline.
interface bmu_cnt_pipe_if #(
    parameter int WIDTH = 32
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_a;
    logic [1:0]               in_op;
    logic                     in_w;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(WIDTH):0]   out_cnt;

    modport master (
        output in_valid, in_a, in_op, in_w, out_ready,
        input  in_ready, out_valid, out_cnt
    );

    modport slave (
        input  in_valid, in_a, in_op, in_w, out_ready,
        output in_ready, out_valid, out_cnt
    );
endinterface

// File: rtl/bmu_cnt_pipe.sv
// Two-stage cpop/ctz/clz unit: S1 holds the operand, S2 holds the registered count.
// Every op reduces to a popcount of a mask, so zero operands need no special case.
module bmu_cnt_pipe #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    bmu_cnt_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        OP_CPOP = 2'b00,
        OP_CTZ  = 2'b01,
        OP_CLZ  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    op_e              op_q, op_d;
    logic             w_q, w_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             s1_adv, s2_adv, accept, word;
    logic [WIDTH-1:0] x, rev_full, rev, m_raw, m;
    logic [31:0]      rev32;
    logic [CW-1:0]    pop;

    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = s1_valid_q && s2_adv;
    assign bus.in_ready = !s1_valid_q || s2_adv;
    assign accept       = bus.in_valid && bus.in_ready && !flush;

    // Word ops only exist on the 64-bit build; the low word is zero-extended.
    assign word = w_q && (WIDTH == 64);
    assign x    = word ? WIDTH'(a_q[31:0]) : a_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev_full
        assign rev_full[i] = x[WIDTH-1-i];
    end
    for (genvar i = 0; i < 32; i++) begin : g_rev32
        assign rev32[i] = x[31-i];
    end
    assign rev = word ? WIDTH'(rev32) : rev_full;

    function automatic logic [WIDTH-1:0] below_lsb(input logic [WIDTH-1:0] v);
        return ~v & (v - WIDTH'(1));
    endfunction

    always_comb begin
        m_raw = '0;
        case (op_q)
            OP_CPOP: m_raw = x;
            OP_CTZ:  m_raw = below_lsb(x);
            OP_CLZ:  m_raw = below_lsb(rev);
            default: m_raw = '0;
        endcase
    end

    // A zero word operand makes the mask all ones; clip it back to 32 bits.
    assign m = word ? (m_raw & WIDTH'(64'h0000_0000_FFFF_FFFF)) : m_raw;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + CW'(m[i]);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        a_d        = a_q;
        op_d       = op_q;
        w_d        = w_q;
        cnt_d      = cnt_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) cnt_d = pop;
        end
        if (s1_adv) s1_valid_d = 1'b0;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = bus.in_a;
            op_d       = op_e'(bus.in_op);
            w_d        = bus.in_w;
        end
        // Flush only kills the valid bits; data registers keep stale contents.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            op_q       <= OP_CPOP;
            w_q        <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            a_q        <= a_d;
            op_q       <= op_d;
            w_q        <= w_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_cnt   = s2_valid_q ? cnt_q : '0;
endmodule

// File: tb/tb_bmu_cnt_pipe.sv
// Scoreboard bench for bmu_cnt_pipe: one 64-bit and one 32-bit instance.
module tb_bmu_cnt_pipe;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;
    always #5 clk = ~clk;

    bmu_cnt_pipe_if #(.WIDTH(64)) b64 ();
    bmu_cnt_pipe_if #(.WIDTH(32)) b32 ();

    bmu_cnt_pipe #(.WIDTH(64)) dut64 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64));
    bmu_cnt_pipe #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32));

    typedef struct {
        int cnt;
        int cyc;
        bit lat;
    } exp_t;

    exp_t       q64[$];
    exp_t       q32[$];
    exp_t       e64, e32;
    int         n_chk = 0, n_err = 0;
    int         cyc = 0, rst_cnt = 0, rst_seen = 0;
    bit         lat_on = 1'b1;
    bit         rnd_done;
    logic       stall_q = 1'b0;
    logic [6:0] hold_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset_n) rst_cnt <= rst_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Independent reference: count bits by walking them, not by masking.
    function automatic int ref_cnt(input int width, input logic [63:0] a,
                                   input logic [1:0] op, input bit w);
        int n = (w && width == 64) ? 32 : width;
        int c = 0;
        case (op)
            2'b00: for (int i = 0; i < n; i++) c += int'(a[i]);
            2'b01: while (c < n && !a[c]) c++;
            2'b10: while (c < n && !a[n-1-c]) c++;
            default: c = 0;
        endcase
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one op (caller is just past a rising edge); push its expectation on acceptance.
    task automatic drv(input bit s64, input logic [63:0] a, input logic [1:0] op,
                       input bit w, input int exp_cnt);
        int   n = 0;
        bit   ok = 0;
        exp_t e;
        if (s64) begin
            b64.in_valid = 1'b1; b64.in_a = a; b64.in_op = op; b64.in_w = w;
        end else begin
            b32.in_valid = 1'b1; b32.in_a = a[31:0]; b32.in_op = op; b32.in_w = w;
        end
        while (!ok && n <= 100) begin
            @(negedge clk);
            ok = (s64 ? b64.in_ready : b32.in_ready) && !flush;
            n++;
        end
        if (!ok) chk("acc_timeout", s64 ? b64.in_ready : b32.in_ready, 1);
        else begin
            e.cnt = exp_cnt; e.cyc = cyc; e.lat = lat_on;
            if (s64) q64.push_back(e);
            else     q32.push_back(e);
        end
        tick(1);
        if (s64) b64.in_valid = 1'b0;
        else     b32.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q64.size() + q32.size(), 0);
        tick(1);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (!b64.out_valid) chk("idle_cnt64", b64.out_cnt, 0);
            if (stall_q && rst_seen == rst_cnt) begin
                chk("hold_vld64", b64.out_valid, 1);
                chk("hold_cnt64", b64.out_cnt, hold_cnt);
            end
            if (b64.out_valid && b64.out_ready) begin
                if (q64.size() == 0) chk("extra64", q64.size(), 1);
                else begin
                    e64 = q64.pop_front();
                    chk("cnt64", b64.out_cnt, e64.cnt);
                    if (e64.lat) chk("lat64", cyc - e64.cyc, 2);
                end
            end
            stall_q  <= b64.out_valid && !b64.out_ready && !flush;
            hold_cnt <= b64.out_cnt;
            rst_seen <= rst_cnt;
        end
    end

    always @(negedge clk) begin
        if (reset_n && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) chk("extra32", q32.size(), 1);
            else begin
                e32 = q32.pop_front();
                chk("cnt32", b32.out_cnt, e32.cnt);
                if (e32.lat) chk("lat32", cyc - e32.cyc, 2);
            end
        end
    end

    initial begin
        logic [63:0] a;
        logic [1:0]  op;
        bit          w;

        b64.in_valid = 0; b64.in_a = '0; b64.in_op = 0; b64.in_w = 0; b64.out_ready = 1;
        b32.in_valid = 0; b32.in_a = '0; b32.in_op = 0; b32.in_w = 0; b32.out_ready = 1;

        // Reset values, both while asserted and on the first cycle after release.
        #12;
        chk("rst_rdy64", b64.in_ready, 1);
        chk("rst_vld64", b64.out_valid, 0);
        chk("rst_cnt64", b64.out_cnt, 0);
        chk("rst_rdy32", b32.in_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", b64.in_ready, 1);
        chk("post_rst_vld", b64.out_valid, 0);
        tick(1);

        // 32-bit directed, back-to-back with latency checks.
        drv(0, 64'hF0F0_0001, 2'b00, 0, 9);
        drv(0, 64'h0,         2'b01, 0, 32);
        drv(0, 64'h0,         2'b10, 0, 32);
        drv(0, 64'h0001_0000, 2'b10, 0, 15);
        drv(0, 64'h0000_0100, 2'b01, 1, 8);

        // 64-bit directed, including word ops and the reserved op.
        drv(1, 64'h8000_0000_0000_0000, 2'b01, 0, 63);
        drv(1, 64'h0000_0000_0000_0001, 2'b10, 0, 63);
        drv(1, 64'h0,                   2'b10, 0, 64);
        drv(1, 64'h0,                   2'b01, 0, 64);
        drv(1, 64'hFFFF_FFFF_0000_0001, 2'b10, 1, 31);
        drv(1, 64'hFFFF_FFFF_0000_0000, 2'b01, 1, 32);
        drv(1, 64'hFFFF_FFFF_0000_0003, 2'b00, 1, 2);
        drv(1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 64);
        drv(1, 64'hDEAD_BEEF_0000_0000, 2'b11, 0, 0);
        drain();

        // Backpressure: downstream stalls for three cycles mid-burst.
        lat_on = 0;
        fork
            begin
                drv(1, 64'h1, 2'b00, 0, 1);
                drv(1, 64'h3, 2'b00, 0, 2);
                drv(1, 64'h7, 2'b00, 0, 3);
            end
            begin
                tick(2);
                b64.out_ready = 1'b0;
                @(negedge clk);
                chk("bp_inrdy", b64.in_ready, 0);
                chk("bp_vld", b64.out_valid, 1);
                tick(3);
                b64.out_ready = 1'b1;
            end
        join
        drain();

        // Flush with both stages full and a new op offered.
        b64.out_ready = 1'b0;
        drv(1, 64'h3, 2'b00, 0, 2);
        drv(1, 64'h7, 2'b00, 0, 3);
        flush = 1'b1; b64.in_valid = 1'b1; b64.in_a = 64'hFF; b64.in_op = 2'b00;
        tick(1);
        flush = 1'b0; b64.in_valid = 1'b0;
        q64.delete();
        @(negedge clk);
        chk("fl_vld", b64.out_valid, 0);
        chk("fl_rdy", b64.in_ready, 1);
        chk("fl_cnt", b64.out_cnt, 0);
        tick(1);
        b64.out_ready = 1'b1;
        // Flush must also win over an acceptance into an empty pipe.
        flush = 1'b1; b64.in_valid = 1'b1; b64.in_a = 64'h1F;
        tick(1);
        flush = 1'b0; b64.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fl_drop_vld", b64.out_valid, 0);
        end
        tick(1);

        // Asynchronous reset while a result is held at the output.
        b64.out_ready = 1'b0;
        drv(1, 64'hF, 2'b00, 0, 4);
        @(posedge clk);
        #2;
        chk("ar_pre_vld", b64.out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_vld", b64.out_valid, 0);
        chk("ar_cnt", b64.out_cnt, 0);
        chk("ar_rdy", b64.in_ready, 1);
        #1;
        reset_n = 1'b1;
        q64.delete();
        @(negedge clk);
        chk("ar_first_rdy", b64.in_ready, 1);
        chk("ar_first_vld", b64.out_valid, 0);
        tick(1);
        b64.out_ready = 1'b1;
        lat_on = 1;
        drv(1, 64'h0000_0000_0001_0000, 2'b01, 0, 16);
        drain();

        // Random ops against random downstream readiness.
        lat_on = 0;
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    case ($urandom_range(0, 3))
                        0:       a = 64'h0;
                        1:       a = 64'h1 << $urandom_range(0, 63);
                        default: a = {$urandom(), $urandom()};
                    endcase
                    op = 2'($urandom_range(0, 3));
                    w  = 1'($urandom_range(0, 1));
                    drv(1, a, op, w, ref_cnt(64, a, op, w));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    tick(1);
                    b64.out_ready = ($urandom_range(0, 3) != 0);
                end
                b64.out_ready = 1'b1;
            end
        join
        drain();

        lat_on = 1;
        for (int i = 0; i < 20; i++) begin
            a  = {32'h0, $urandom()};
            op = 2'($urandom_range(0, 3));
            drv(0, a, op, 0, ref_cnt(32, a, op, 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
